// File: rtl/nibbler_if.sv
// nibbler_if: control bundle between the nibbler sequencer and its datapath.
// The sequencer uses the master modport and the datapath uses the slave modport.
// The halt_req, step and halted signals exist only when NIBBLER_STEP_EN is defined.
interface nibbler_if;
    // Datapath -> sequencer
    logic [3:0]  opcode;
    logic        carry;
    logic        zero;
`ifdef NIBBLER_STEP_EN
    logic        halt_req;
    logic        step;
`endif

    // Sequencer -> datapath
    logic        phase;
    logic        ir_we;
    logic        pc_inc;
    logic        pc_ld;
    logic [1:0]  alu_op;
    logic        src_mem;
    logic        a_we;
    logic        flags_we;
    logic        ram_we;
    logic        ram_oe;
    logic        out_we;
    logic        in_oe;
    logic [15:0] instr_count;
`ifdef NIBBLER_STEP_EN
    logic        halted;
`endif

`ifdef NIBBLER_STEP_EN
    modport master (
        input  opcode, carry, zero, halt_req, step,
        output phase, ir_we, pc_inc, pc_ld, alu_op, src_mem, a_we, flags_we,
               ram_we, ram_oe, out_we, in_oe, instr_count, halted
    );

    modport slave (
        output opcode, carry, zero, halt_req, step,
        input  phase, ir_we, pc_inc, pc_ld, alu_op, src_mem, a_we, flags_we,
               ram_we, ram_oe, out_we, in_oe, instr_count, halted
    );
`else
    modport master (
        input  opcode, carry, zero,
        output phase, ir_we, pc_inc, pc_ld, alu_op, src_mem, a_we, flags_we,
               ram_we, ram_oe, out_we, in_oe, instr_count
    );

    modport slave (
        output opcode, carry, zero,
        input  phase, ir_we, pc_inc, pc_ld, alu_op, src_mem, a_we, flags_we,
               ram_we, ram_oe, out_we, in_oe, instr_count
    );
`endif
endinterface

// File: rtl/nibbler_sequencer.sv
// nibbler_sequencer: two-cycle (FETCH then EXEC) control sequencer for a
// 4-bit accumulator CPU. FETCH loads the instruction register and increments
// the PC. EXEC decodes the opcode and flags combinationally into datapath
// strobes. A 16-bit counter tracks retired instructions.
// Optional feature: define NIBBLER_STEP_EN to add the halt_req/step inputs,
// the halted output and a HALT state for single-stepping.
module nibbler_sequencer (
    input  logic      clk,
    input  logic      reset,
    nibbler_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
`ifdef NIBBLER_STEP_EN
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
`else
        ST_EXEC  = 2'd2
`endif
    } state_e;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0,
        OP_JNC  = 4'h1,
        OP_JZ   = 4'h2,
        OP_JNZ  = 4'h3,
        OP_JMP  = 4'h4,
        OP_NOP  = 4'h5,
        OP_OUT  = 4'h6,
        OP_IN   = 4'h7,
        OP_LIT  = 4'h8,
        OP_ADDI = 4'h9,
        OP_CMPI = 4'hA,
        OP_NORI = 4'hB,
        OP_LD   = 4'hC,
        OP_ADDM = 4'hD,
        OP_ST   = 4'hE,
        OP_NORM = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_PASS_B = 2'b00,
        ALU_ADD    = 2'b01,
        ALU_SUB    = 2'b10,
        ALU_NOR    = 2'b11
    } alu_op_e;

    // Strobes that only EXEC can raise.
    typedef struct packed {
        logic    pc_ld;
        alu_op_e alu_op;
        logic    src_mem;
        logic    a_we;
        logic    flags_we;
        logic    ram_we;
        logic    ram_oe;
        logic    out_we;
        logic    in_oe;
    } exec_strobes_t;

    state_e        state_q, state_d;
    logic          phase_q, phase_d;    // high in EXEC
    logic          fetch_q, fetch_d;    // high in FETCH (ir_we and pc_inc)
    logic [15:0]   instr_count_q, instr_count_d;
    exec_strobes_t exec_strb;

`ifdef NIBBLER_STEP_EN
    logic          halted_q, halted_d;
    logic          step_q, step_d;      // step delayed one cycle for edge detection
    logic          step_rise;

    assign step_rise = bus.step & ~step_q;
`endif

    // Next state, retire counter and the state-derived output bits.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d       = ST_IDLE;
        instr_count_d = instr_count_q;

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                // Leaving EXEC retires the instruction. The 16-bit add wraps from 0xFFFF to 0.
                instr_count_d = instr_count_q + 16'd1;
`ifdef NIBBLER_STEP_EN
                state_d = bus.halt_req ? ST_HALT : ST_FETCH;
`else
                state_d = ST_FETCH;
`endif
            end
`ifdef NIBBLER_STEP_EN
            // Leave HALT when halt_req drops, or run one instruction on a new step press.
            ST_HALT:  state_d = (!bus.halt_req || step_rise) ? ST_FETCH : ST_HALT;
`endif
            default:  state_d = ST_IDLE;    // any corrupted encoding recovers via IDLE
        endcase

        // Register the outputs from the next state so they are glitch-free flop outputs.
        phase_d = (state_d == ST_EXEC);
        fetch_d = (state_d == ST_FETCH);
`ifdef NIBBLER_STEP_EN
        halted_d = (state_d == ST_HALT);
        step_d   = bus.step;
`endif
    end

    // State, counter and registered output flops with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the pre-edge value of every other flop.
        if (reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= 1'b0;
            fetch_q       <= 1'b0;
            instr_count_q <= '0;
`ifdef NIBBLER_STEP_EN
            halted_q      <= 1'b0;
            step_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            fetch_q       <= fetch_d;
            instr_count_q <= instr_count_d;
`ifdef NIBBLER_STEP_EN
            halted_q      <= halted_d;
            step_q        <= step_d;
`endif
        end
    end

    // EXEC strobes decoded from the live opcode and the flags as sampled in this cycle.
    always_comb begin
        exec_strb = '0;
        if (phase_q) begin
            case (opcode_e'(bus.opcode))
                OP_JC:   exec_strb.pc_ld = bus.carry;
                OP_JNC:  exec_strb.pc_ld = ~bus.carry;
                OP_JZ:   exec_strb.pc_ld = bus.zero;
                OP_JNZ:  exec_strb.pc_ld = ~bus.zero;
                OP_JMP:  exec_strb.pc_ld = 1'b1;
                OP_NOP:  ;
                OP_OUT:  exec_strb.out_we = 1'b1;
                OP_IN: begin
                    exec_strb.in_oe = 1'b1;
                    exec_strb.a_we  = 1'b1;
                end
                OP_LIT: begin
                    exec_strb.alu_op = ALU_PASS_B;
                    exec_strb.a_we   = 1'b1;
                end
                OP_ADDI: begin
                    exec_strb.alu_op   = ALU_ADD;
                    exec_strb.a_we     = 1'b1;
                    exec_strb.flags_we = 1'b1;
                end
                OP_CMPI: begin
                    exec_strb.alu_op   = ALU_SUB;
                    exec_strb.flags_we = 1'b1;
                end
                OP_NORI: begin
                    exec_strb.alu_op   = ALU_NOR;
                    exec_strb.a_we     = 1'b1;
                    exec_strb.flags_we = 1'b1;
                end
                OP_LD: begin
                    exec_strb.ram_oe  = 1'b1;
                    exec_strb.src_mem = 1'b1;
                    exec_strb.alu_op  = ALU_PASS_B;
                    exec_strb.a_we    = 1'b1;
                end
                OP_ADDM: begin
                    exec_strb.ram_oe   = 1'b1;
                    exec_strb.src_mem  = 1'b1;
                    exec_strb.alu_op   = ALU_ADD;
                    exec_strb.a_we     = 1'b1;
                    exec_strb.flags_we = 1'b1;
                end
                OP_ST:   exec_strb.ram_we = 1'b1;
                OP_NORM: begin
                    exec_strb.ram_oe   = 1'b1;
                    exec_strb.src_mem  = 1'b1;
                    exec_strb.alu_op   = ALU_NOR;
                    exec_strb.a_we     = 1'b1;
                    exec_strb.flags_we = 1'b1;
                end
            endcase
        end
    end

    assign bus.phase       = phase_q;
    assign bus.ir_we       = fetch_q;
    assign bus.pc_inc      = fetch_q;
    assign bus.pc_ld       = exec_strb.pc_ld;
    assign bus.alu_op      = exec_strb.alu_op;
    assign bus.src_mem     = exec_strb.src_mem;
    assign bus.a_we        = exec_strb.a_we;
    assign bus.flags_we    = exec_strb.flags_we;
    assign bus.ram_we      = exec_strb.ram_we;
    assign bus.ram_oe      = exec_strb.ram_oe;
    assign bus.out_we      = exec_strb.out_we;
    assign bus.in_oe       = exec_strb.in_oe;
    assign bus.instr_count = instr_count_q;
`ifdef NIBBLER_STEP_EN
    assign bus.halted      = halted_q;
`endif

    // The datapath must never see both PC sources or both RAM directions at once.
    a_pc_source_exclusive: assert property (@(posedge clk) !(bus.pc_inc && bus.pc_ld));
    a_ram_dir_exclusive:   assert property (@(posedge clk) !(bus.ram_we && bus.ram_oe));

endmodule

// File: tb/tb_nibbler_sequencer.sv
// tb_nibbler_sequencer: directed bench for nibbler_sequencer.
// The reference model is cycle-count arithmetic. After a reset edge, cycle 0
// is idle, odd cycles are fetches and even cycles are executes. Expected
// strobes come from a per-opcode table. A compare process checks the DUT on
// every falling edge, and literal checks pin the model at key points.
module tb_nibbler_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nibbler_if bus();

    nibbler_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Model state: non-reset edges since the last reset edge.
    int          cyc         = 0;
    bit          model_valid = 1'b0;
    bit          model_en    = 1'b1;
    logic [15:0] base_adj    = 16'h0000;

    // Non-jump EXEC strobes per opcode:
    // {alu_op[1:0], src_mem, a_we, flags_we, ram_we, ram_oe, out_we, in_oe}
    logic [8:0] exec_table [16] = '{
        9'b00_0_0_0_0_0_0_0,   // 0 JC
        9'b00_0_0_0_0_0_0_0,   // 1 JNC
        9'b00_0_0_0_0_0_0_0,   // 2 JZ
        9'b00_0_0_0_0_0_0_0,   // 3 JNZ
        9'b00_0_0_0_0_0_0_0,   // 4 JMP
        9'b00_0_0_0_0_0_0_0,   // 5 NOP
        9'b00_0_0_0_0_0_1_0,   // 6 OUT
        9'b00_0_1_0_0_0_0_1,   // 7 IN
        9'b00_0_1_0_0_0_0_0,   // 8 LIT
        9'b01_0_1_1_0_0_0_0,   // 9 ADDI
        9'b10_0_0_1_0_0_0_0,   // A CMPI
        9'b11_0_1_1_0_0_0_0,   // B NORI
        9'b00_1_1_0_0_1_0_0,   // C LD
        9'b01_1_1_1_0_1_0_0,   // D ADDM
        9'b00_0_0_0_1_0_0_0,   // E ST
        9'b11_1_1_1_0_1_0_0    // F NORM
    };

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic logic [12:0] outvec();
        return {bus.phase, bus.ir_we, bus.pc_inc, bus.pc_ld, bus.alu_op, bus.src_mem,
                bus.a_we, bus.flags_we, bus.ram_we, bus.ram_oe, bus.out_we, bus.in_oe};
    endfunction

    // Expected output vector from the cycle role and the instruction rules.
    function automatic logic [12:0] expected_outputs(int c, logic [3:0] op, logic cy, logic zf);
        logic flag;
        logic taken;
        if (c == 0) return 13'h0;
        if (c % 2 == 1) return 13'b0_1_1_0_00_0_0_0_0_0_0_0;
        flag  = op[1] ? zf : cy;
        taken = (op == 4'd4) || ((op < 4'd4) && (op[0] ? ~flag : flag));
        return {1'b1, 1'b0, 1'b0, taken, exec_table[op]};
    endfunction

    function automatic logic [15:0] expected_count(int c);
        return base_adj + 16'((c < 1) ? 0 : (c - 1) / 2);
    endfunction

    // Model clock: advance the cycle index, or restart it on a reset edge.
    always @(posedge clk) begin
        if (reset) begin
            cyc         <= 0;
            model_valid <= 1'b1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    // Compare process: check every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid && model_en) begin
            check("outputs_vs_model", 32'(outvec()),
                  32'(expected_outputs(cyc, bus.opcode, bus.carry, bus.zero)));
            check("instr_count_vs_model", 32'(bus.instr_count), 32'(expected_count(cyc)));
            check("pc_inc_pc_ld_exclusive", 32'(bus.pc_inc & bus.pc_ld), 32'd0);
            check("ram_we_ram_oe_exclusive", 32'(bus.ram_we & bus.ram_oe), 32'd0);
`ifdef NIBBLER_STEP_EN
            check("halted_low_when_running", 32'(bus.halted), 32'd0);
`endif
        end
    end

    // Drive one cycle's inputs just after the edge, then wait for the sampling edge.
    task automatic cycle(input logic rst, input logic [3:0] op, input logic cy, input logic zf);
        @(posedge clk);
        #1;
        reset      = rst;
        bus.opcode = op;
        bus.carry  = cy;
        bus.zero   = zf;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, actual unfinished, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef NIBBLER_STEP_EN
        int fetches;
        int execs;
`endif
        reset      = 1'b1;
        bus.opcode = 4'h0;
        bus.carry  = 1'b0;
        bus.zero   = 1'b0;
`ifdef NIBBLER_STEP_EN
        bus.halt_req = 1'b0;
        bus.step     = 1'b0;
`endif

        // Reset held for three cycles: everything is quiet and the counter is zero.
        repeat (3) begin
            cycle(1'b1, 4'h0, 1'b0, 1'b0);
            check("reset_outputs", 32'(outvec()), 32'd0);
            check("reset_count", 32'(bus.instr_count), 32'd0);
        end

        // Release: one idle cycle, then FETCH, then a taken and an untaken JC.
        cycle(1'b0, 4'h0, 1'b0, 1'b0);
        check("idle_after_release", 32'(outvec()), 32'd0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("first_fetch_strobes", 32'({bus.ir_we, bus.pc_inc, bus.phase}), 32'(3'b110));
        check("first_fetch_count", 32'(bus.instr_count), 32'd0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("jc_taken_pc_ld", 32'(bus.pc_ld), 32'd1);
        check("jc_taken_pc_inc", 32'(bus.pc_inc), 32'd0);
        check("jc_taken_phase", 32'(bus.phase), 32'd1);
        cycle(1'b0, 4'h0, 1'b0, 1'b0);
        check("second_fetch_count", 32'(bus.instr_count), 32'd1);
        cycle(1'b0, 4'h0, 1'b0, 1'b0);
        check("jc_untaken_pc_ld", 32'(bus.pc_ld), 32'd0);
        check("jc_untaken_pc_inc", 32'(bus.pc_inc), 32'd0);

        // Sweep every opcode under all four flag combinations.
        for (int op = 0; op < 16; op++) begin
            for (int f = 0; f < 4; f++) begin
                cycle(1'b0, 4'(op), f[0], f[1]);
                cycle(1'b0, 4'(op), f[0], f[1]);
                if (op == 13 && f == 0)
                    check("addm_exec_literal", 32'(outvec()), 32'(13'b1_0_0_0_01_1_1_1_0_1_0_0));
                if (op == 3 && f == 2)
                    check("jnz_zero_set_untaken", 32'(bus.pc_ld), 32'd0);
            end
        end

        // Counter wrap: preload 0xFFFE during a FETCH, then retire two more instructions.
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        #2;
        force dut.instr_count_q = 16'hFFFE;
        base_adj = 16'hFFFE - 16'((cyc - 1) / 2);
        @(posedge clk);
        #1;
        release dut.instr_count_q;
        @(negedge clk);
        check("preload_count", 32'(bus.instr_count), 32'h0000FFFE);
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        check("count_ffff", 32'(bus.instr_count), 32'h0000FFFF);
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        check("count_wrap_to_zero", 32'(bus.instr_count), 32'd0);
        cycle(1'b0, 4'h5, 1'b0, 1'b0);

        // Reset asserted in the middle of an ADDM execute.
        cycle(1'b0, 4'hD, 1'b1, 1'b1);
        cycle(1'b0, 4'hD, 1'b1, 1'b1);
        check("addm_before_reset", 32'(bus.ram_oe & bus.a_we & bus.phase), 32'd1);
        #1;
        reset    = 1'b1;
        base_adj = 16'h0000;
        cycle(1'b1, 4'hD, 1'b1, 1'b1);
        check("reset_mid_exec_outputs", 32'(outvec()), 32'd0);
        check("reset_mid_exec_count", 32'(bus.instr_count), 32'd0);
        cycle(1'b0, 4'hD, 1'b1, 1'b1);
        check("idle_after_mid_exec_reset", 32'(outvec()), 32'd0);

`ifdef NIBBLER_STEP_EN
        // Halt after the current EXEC, single-step once, then resume.
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        bus.halt_req = 1'b1;
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        check("exec_before_halt", 32'(bus.phase), 32'd1);
        model_en = 1'b0;
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        check("halted_set", 32'(bus.halted), 32'd1);
        check("halted_strobes_zero", 32'(outvec()), 32'd0);
        check("halted_count", 32'(bus.instr_count), 32'd1);
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        check("halted_holds", 32'(bus.halted), 32'd1);
        fetches = 0;
        execs   = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            bus.step = 1'b1;
            @(negedge clk);
            fetches += int'(bus.ir_we);
            execs   += int'(bus.phase);
        end
        bus.step = 1'b0;
        check("step_one_fetch", 32'(fetches), 32'd1);
        check("step_one_exec", 32'(execs), 32'd1);
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        check("halted_after_step", 32'(bus.halted), 32'd1);
        check("count_after_step", 32'(bus.instr_count), 32'd2);
        @(posedge clk);
        #1;
        bus.halt_req = 1'b0;
        @(negedge clk);
        cycle(1'b0, 4'h5, 1'b0, 1'b0);
        check("resume_fetch", 32'({bus.ir_we, bus.halted}), 32'(2'b10));
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        model_en = 1'b1;
`endif

        // A few more instructions under the model after the last reset.
        cycle(1'b0, 4'h9, 1'b0, 1'b0);
        cycle(1'b0, 4'h9, 1'b0, 1'b0);
        cycle(1'b0, 4'h4, 1'b0, 1'b0);
        cycle(1'b0, 4'h4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
